ad_frame_packer: RTL



---
 rtl/ad_pkt_pkg.sv | 19 +
 rtl/pkt_bank_ctrl.sv | 56 +++++
 rtl/ad_frame_packer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ad_pkt_pkg.sv
// rtl/ad_pkt_pkg.sv - shared constants and state encoding for the AD frame packer
package ad_pkt_pkg;

    localparam logic [15:0] PKT_HDR    = 16'hA55A;
    localparam int          HDR_OFS    = 0;
    localparam int          CNT_OFS    = 1;
    localparam int          DATA_OFS   = 2;
    localparam logic [1:0]  CREDIT_MAX = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_CNT  = 3'd2,
        ST_DATA = 3'd3,
        ST_SUM  = 3'd4,
        ST_EOP  = 3'd5
    } pkt_state_e;

endpackage

// File: rtl/pkt_bank_ctrl.sv
// rtl/pkt_bank_ctrl.sv - TX bank ping-pong, bank credits and frame drop counting
module pkt_bank_ctrl
    import ad_pkt_pkg::*;
#(
    parameter int BADDR_NBIT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  done,
    input  logic                  tx_ack,
    output logic                  has_credit,
    output logic [BADDR_NBIT-1:0] wr_bank,
    output logic [BADDR_NBIT-1:0] tx_baddr,
    output logic [7:0]            drop_cnt
);

    logic [1:0]            credit_q, credit_d;
    logic [BADDR_NBIT-1:0] bank_q, bank_d;
    logic [BADDR_NBIT-1:0] baddr_q, baddr_d;
    logic [7:0]            drop_q, drop_d;

    // Credit, bank and drop registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q <= CREDIT_MAX;
            bank_q   <= '0;
            baddr_q  <= '0;
            drop_q   <= '0;
        end else begin
            credit_q <= credit_d;
            bank_q   <= bank_d;
            baddr_q  <= baddr_d;
            drop_q   <= drop_d;
        end
    end

    // A finished packet consumes a bank; an ack in the same cycle hands it straight back
    always_comb begin
        credit_d = credit_q;
        if (done && !tx_ack) begin
            credit_d = credit_q - 2'd1;
        end else if (!done && tx_ack && credit_q != CREDIT_MAX) begin
            credit_d = credit_q + 2'd1;
        end
        bank_d  = done ? bank_q + BADDR_NBIT'(1) : bank_q;
        baddr_d = done ? bank_q : baddr_q;
        drop_d  = (req && credit_q == 2'd0 && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    end

    assign has_credit = (credit_q != 2'd0);
    assign wr_bank    = bank_q;
    assign tx_baddr   = baddr_q;
    assign drop_cnt   = drop_q;

endmodule

// File: rtl/ad_frame_packer.sv
// rtl/ad_frame_packer.sv - packs one AD cache half per event into a TX buffer packet; checksum word enabled by AD_PKT_CHECKSUM_EN
module ad_frame_packer
    import ad_pkt_pkg::*;
#(
    parameter int FRAME_WORDS = 256,
    parameter int DATA_NBIT   = 16,
    parameter int ADDR_NBIT   = 11,
    parameter int BADDR_NBIT  = 1
) (
    input  logic                  mclk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  ad_switch,
    output logic                  ad_rd,
    input  logic [DATA_NBIT-1:0]  ad_data,
    output logic                  tx_vd,
    output logic [ADDR_NBIT-1:0]  tx_addr,
    output logic [DATA_NBIT-1:0]  tx_data,
    output logic                  tx_eop,
    output logic [BADDR_NBIT-1:0] tx_baddr,
    input  logic                  tx_ack,
    output logic [7:0]            drop_cnt,
    output logic                  overrun
);

    localparam int            IW       = ADDR_NBIT - BADDR_NBIT;
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_WORDS - 1);

    pkt_state_e            state_q, state_d;
    logic                  sw_q;
    logic                  ev_acc, is_idle, start_req, has_credit, done;
    logic [IW-1:0]         cnt_q, cnt_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  pend_q, pend_d;
    logic                  ovr_q, ovr_d;
    logic                  eop_q, eop_d;
    logic                  wr_vd_q, wr_vd_d;
    logic                  wr_sel_q, wr_sel_d;
    logic [IW-1:0]         wr_idx_q, wr_idx_d;
    logic [DATA_NBIT-1:0]  wr_word_q, wr_word_d;
    logic [BADDR_NBIT-1:0] wr_bank;
`ifdef AD_PKT_CHECKSUM_EN
    logic [DATA_NBIT-1:0]  sum_q, sum_d;
`endif

    // Half-full flag copy tracks the input even in reset, so leaving reset never fakes an event
    always_ff @(posedge mclk) begin
        sw_q <= ad_switch;
    end

    assign ev_acc    = (ad_switch ^ sw_q) & en;
    assign is_idle   = (state_q == ST_IDLE);
    assign start_req = is_idle & (ev_acc | pend_q);
    assign done      = (state_q == ST_EOP);

    pkt_bank_ctrl #(
        .BADDR_NBIT (BADDR_NBIT)
    ) u_bank_ctrl (
        .clk        (mclk),
        .rst_n      (rst_n),
        .req        (start_req),
        .done       (done),
        .tx_ack     (tx_ack),
        .has_credit (has_credit),
        .wr_bank    (wr_bank),
        .tx_baddr   (tx_baddr),
        .drop_cnt   (drop_cnt)
    );

    // State register plus packet bookkeeping and the one-cycle write stage
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
            pend_q      <= 1'b0;
            ovr_q       <= 1'b0;
            eop_q       <= 1'b0;
            wr_vd_q     <= 1'b0;
            wr_sel_q    <= 1'b0;
            wr_idx_q    <= '0;
            wr_word_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
            pend_q      <= pend_d;
            ovr_q       <= ovr_d;
            eop_q       <= eop_d;
            wr_vd_q     <= wr_vd_d;
            wr_sel_q    <= wr_sel_d;
            wr_idx_q    <= wr_idx_d;
            wr_word_q   <= wr_word_d;
        end
    end

    // Next state: header, counter, samples, optional sum, end of packet
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_req && has_credit) state_d = ST_HDR;
            ST_HDR:  state_d = ST_CNT;
            ST_CNT:  state_d = ST_DATA;
            ST_DATA: begin
                if (cnt_q == LAST_IDX) begin
`ifdef AD_PKT_CHECKSUM_EN
                    state_d = ST_SUM;
`else
                    state_d = ST_EOP;
`endif
                end
            end
            ST_SUM:  state_d = ST_EOP;
            ST_EOP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Sample counter, frame counter, pending event and overrun tracking
    always_comb begin
        cnt_d       = (state_q == ST_DATA) ? cnt_q + IW'(1) : '0;
        frame_cnt_d = (state_q == ST_CNT) ? frame_cnt_q + 16'd1 : frame_cnt_q;
        pend_d      = pend_q;
        ovr_d       = ovr_q;
        if (is_idle) begin
            if (start_req) begin
                pend_d = ev_acc & pend_q;
            end
        end else if (ev_acc) begin
            if (pend_q) begin
                ovr_d = 1'b1;
            end else begin
                pend_d = 1'b1;
            end
        end
    end

    // Outputs: cache read strobe and the word staged for the next cycle's TX write
    always_comb begin
        ad_rd     = 1'b0;
        eop_d     = 1'b0;
        wr_vd_d   = 1'b0;
        wr_sel_d  = 1'b0;
        wr_idx_d  = '0;
        wr_word_d = '0;
        case (state_q)
            ST_HDR: begin
                wr_vd_d   = 1'b1;
                wr_idx_d  = IW'(HDR_OFS);
                wr_word_d = DATA_NBIT'(PKT_HDR);
            end
            ST_CNT: begin
                wr_vd_d   = 1'b1;
                wr_idx_d  = IW'(CNT_OFS);
                wr_word_d = DATA_NBIT'(frame_cnt_q);
            end
            ST_DATA: begin
                ad_rd    = 1'b1;
                wr_vd_d  = 1'b1;
                wr_sel_d = 1'b1;
                wr_idx_d = IW'(DATA_OFS) + cnt_q;
            end
`ifdef AD_PKT_CHECKSUM_EN
            ST_SUM: begin
                wr_vd_d   = 1'b1;
                wr_idx_d  = IW'(DATA_OFS + FRAME_WORDS);
                wr_word_d = sum_q + ad_data;
            end
`endif
            ST_EOP: eop_d = 1'b1;
            default: ;
        endcase
    end

`ifdef AD_PKT_CHECKSUM_EN
    // Running sum register
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    // Accumulate each sample while it is on the TX bus; the last one is added in the SUM state
    always_comb begin
        sum_d = sum_q;
        if (state_q == ST_HDR) begin
            sum_d = '0;
        end else if (wr_sel_q) begin
            sum_d = sum_q + ad_data;
        end
    end
`endif

    // Samples are written straight from the cache data the cycle they become valid
    assign tx_vd   = wr_vd_q;
    assign tx_addr = {wr_bank, wr_idx_q};
    assign tx_data = wr_sel_q ? ad_data : wr_word_q;
    assign tx_eop  = eop_q;
    assign overrun = ovr_q;

endmodule
